// File: rtl/octal_down_timer.sv
// Loadable multi-digit octal down-counter with start/stop control, a one-cycle
// done pulse at terminal count and optional auto-reload for periodic ticks.
module octal_down_timer #(
    parameter int DIGITS      = 2,
    parameter bit AUTO_RELOAD = 1'b0,
    localparam int W          = 3 * DIGITS
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_start,
    input  logic         i_stop,
    input  logic         i_enable,
    output logic [W-1:0] o_count,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   reload_q, reload_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           term_s;

    // Digit-wise decrement: a digit borrows only when every lower digit is 0.
    function automatic logic [W-1:0] oct_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                r[3*k +: 3] = v[3*k +: 3] - 3'd1;
                borrow      = (v[3*k +: 3] == 3'd0);
            end else begin
                r[3*k +: 3] = v[3*k +: 3];
            end
        end
        return r;
    endfunction

    // State, count, reload and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and count update; load overrides everything, then stop, start, tick.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        term_s   = 1'b0;
        if (i_load) begin
            count_d  = i_load_val;
            reload_d = i_load_val;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_stop) begin
                        state_d = ST_IDLE;
                    end else if (i_start) begin
                        if (count_q != CNT_ZERO) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_DONE;
                            term_s  = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (i_stop) begin
                        state_d = ST_IDLE;
                    end else if (i_enable) begin
                        if (count_q > CNT_ONE) begin
                            count_d = oct_dec(count_q);
                        end else if (AUTO_RELOAD && (reload_q != CNT_ZERO)) begin
                            // Periodic mode never exposes a zero count.
                            count_d = reload_q;
                            term_s  = 1'b1;
                        end else begin
                            count_d = CNT_ZERO;
                            state_d = ST_DONE;
                            term_s  = 1'b1;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (i_stop) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = CNT_ZERO;
                end
            endcase
        end
    end

    // Output decode, registered on the same edge as the state.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_d == ST_RUN) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
        if (term_s) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    assign o_count = count_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_zero  = (count_q == CNT_ZERO);

endmodule
